// File: rtl/dcache_pkg.sv
// Shared geometry, state encoding and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned INDEX_W  = 5;
  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINES    = 2 ** INDEX_W;
  localparam int unsigned WORDS    = 2 ** OFFSET_W;

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [INDEX_W-1:0]  index_t;
  typedef logic [OFFSET_W-1:0] offset_t;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StWrite
  } state_e;

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic index_t addr_index(input addr_t a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic offset_t addr_offset(input addr_t a);
    return a[OFFSET_W-1:0];
  endfunction

  function automatic addr_t make_addr(input tag_t t, input index_t i, input offset_t o);
    return {t, i, o};
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Core load/store port and Data_Memory port of the data cache, bundled as one interface.
interface dcache_if;
  import dcache_pkg::*;

  addr_t CPU_ADDR;
  data_t CPU_WD;
  logic  CPU_RE;
  logic  CPU_WE;
  data_t CPU_RD;
  logic  STALL;
  addr_t MEM_A;
  data_t MEM_WD;
  logic  MEM_WE;
  data_t MEM_RD;

  // Controller view.
  modport slave (
    input  CPU_ADDR, CPU_WD, CPU_RE, CPU_WE, MEM_RD,
    output CPU_RD, STALL, MEM_A, MEM_WD, MEM_WE
  );

  // Core plus memory view.
  modport master (
    output CPU_ADDR, CPU_WD, CPU_RE, CPU_WE, MEM_RD,
    input  CPU_RD, STALL, MEM_A, MEM_WD, MEM_WE
  );

endinterface

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays for the cache: combinational read port, synchronous word write,
// synchronous tag/valid set and a clear-all of the valid bits.
module dcache_line_store
  import dcache_pkg::*;
(
  input  logic    clk_i,
  input  logic    clear_i,
  input  index_t  rd_index_i,
  input  offset_t rd_offset_i,
  output logic    rd_valid_o,
  output tag_t    rd_tag_o,
  output data_t   rd_word_o,
  input  logic    wr_en_i,
  input  index_t  wr_index_i,
  input  offset_t wr_offset_i,
  input  data_t   wr_data_i,
  input  logic    set_en_i,
  input  index_t  set_index_i,
  input  tag_t    set_tag_i
);

  logic [LINES-1:0] valid_q;
  tag_t             tag_q  [LINES];
  data_t            data_q [LINES][WORDS];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_word_o  = data_q[rd_index_i][rd_offset_i];

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      valid_q <= '0;
    end else if (set_en_i) begin
      valid_q[set_index_i] <= 1'b1;
    end
  end

  // Tags and data are only meaningful behind a set valid bit, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (set_en_i) begin
      tag_q[set_index_i] <= set_tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[wr_index_i][wr_offset_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with 4-word line
// refill on load miss and a memory latency of MEM_LAT cycles per word.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input logic      CLK,
  input logic      RST,
  dcache_if.slave  bus
);

  localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(MEM_LAT - 1);

  state_e            state_q, state_d;
  offset_t           word_cnt_q, word_cnt_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  tag_t              miss_tag_q, miss_tag_d;
  index_t            miss_idx_q, miss_idx_d;

  logic    rd_valid;
  tag_t    rd_tag;
  data_t   rd_word;
  logic    hit;
  logic    wr_en;
  index_t  wr_index;
  offset_t wr_offset;
  data_t   wr_data;
  logic    set_en;

  logic    stall;
  logic    mem_we;
  addr_t   mem_a;
  data_t   mem_wd;
  data_t   cpu_rd;

  dcache_line_store u_store (
    .clk_i       (CLK),
    .clear_i     (RST),
    .rd_index_i  (addr_index(bus.CPU_ADDR)),
    .rd_offset_i (addr_offset(bus.CPU_ADDR)),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_word_o   (rd_word),
    .wr_en_i     (wr_en),
    .wr_index_i  (wr_index),
    .wr_offset_i (wr_offset),
    .wr_data_i   (wr_data),
    .set_en_i    (set_en),
    .set_index_i (miss_idx_q),
    .set_tag_i   (miss_tag_q)
  );

  assign hit = rd_valid && (rd_tag == addr_tag(bus.CPU_ADDR));

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    stall      = 1'b0;
    mem_we     = 1'b0;
    mem_a      = '0;
    mem_wd     = '0;
    cpu_rd     = '0;
    wr_en      = 1'b0;
    wr_index   = miss_idx_q;
    wr_offset  = word_cnt_q;
    wr_data    = bus.MEM_RD;
    set_en     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.CPU_WE) begin
          // Stores win over loads; a hit keeps the cached copy coherent.
          stall     = 1'b1;
          state_d   = StWrite;
          lat_cnt_d = '0;
          if (hit) begin
            wr_en     = 1'b1;
            wr_index  = addr_index(bus.CPU_ADDR);
            wr_offset = addr_offset(bus.CPU_ADDR);
            wr_data   = bus.CPU_WD;
          end
        end else if (bus.CPU_RE) begin
          if (hit) begin
            cpu_rd = rd_word;
          end else begin
            stall      = 1'b1;
            state_d    = StRefill;
            word_cnt_d = '0;
            lat_cnt_d  = '0;
            miss_tag_d = addr_tag(bus.CPU_ADDR);
            miss_idx_d = addr_index(bus.CPU_ADDR);
          end
        end
      end

      StRefill: begin
        stall = 1'b1;
        mem_a = make_addr(miss_tag_q, miss_idx_q, word_cnt_q);
        if (lat_cnt_q == LatLast) begin
          wr_en      = 1'b1;
          lat_cnt_d  = '0;
          word_cnt_d = word_cnt_q + 1'b1;
          if (&word_cnt_q) begin
            set_en  = 1'b1;
            state_d = StIdle;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      StWrite: begin
        mem_a  = bus.CPU_ADDR;
        mem_wd = bus.CPU_WD;
        mem_we = 1'b1;
        // Release the core in the last write cycle so it retires the store on that edge.
        if (lat_cnt_q == LatLast) begin
          lat_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          stall     = 1'b1;
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (RST) begin
      stall  = 1'b0;
      mem_we = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      cpu_rd = '0;
      wr_en  = 1'b0;
      set_en = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      lat_cnt_q  <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

  assign bus.STALL  = stall;
  assign bus.MEM_WE = mem_we;
  assign bus.MEM_A  = mem_a;
  assign bus.MEM_WD = mem_wd;
  assign bus.CPU_RD = cpu_rd;

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed scenarios then random loads/stores,
// checked against a line-residency reference model with a flat memory image.
module tb_dcache_controller;
  import dcache_pkg::*;

  localparam int unsigned MEM_LAT = 2;

  typedef struct {
    logic [31:0] rd;
    int          stall;
    int          we;
  } exp_t;

  logic clk;
  logic rst;
  bit   mon_en;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  // Memory image: unwritten words read as 255 - address.
  bit          mem_wr [1024];
  logic [31:0] mem_wv [1024];

  // Reference model state.
  logic [31:0] ref_mem   [1024];
  bit          ref_valid [32];
  int          ref_tag   [32];

  dcache_if bus ();

  dcache_controller #(
    .MEM_LAT (MEM_LAT)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  assign bus.MEM_RD = mem_wr[bus.MEM_A] ? mem_wv[bus.MEM_A] : 32'(255 - int'(bus.MEM_A));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      if (bus.MEM_WE === 1'b1) begin
        mem_wr[bus.MEM_A] = 1'b1;
        mem_wv[bus.MEM_A] = bus.MEM_WD;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts STALL and MEM_WE cycles per request, compares on completion.
  initial begin
    int   stall_cnt;
    int   we_cnt;
    exp_t e;
    stall_cnt = 0;
    we_cnt    = 0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        stall_cnt = 0;
        we_cnt    = 0;
      end else if (bus.CPU_RE || bus.CPU_WE) begin
        if (bus.MEM_WE === 1'b1) we_cnt++;
        if (bus.STALL !== 1'b0) begin
          stall_cnt++;
        end else begin
          if (exp_q.size() == 0) begin
            check("unexpected_completion", 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("cpu_rd", bus.CPU_RD, e.rd);
            check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
            check("mem_we_cycles", 32'(we_cnt), 32'(e.we));
          end
          stall_cnt = 0;
          we_cnt    = 0;
        end
      end
    end
  end

  task automatic drive_idle();
    bus.CPU_RE   = 1'b0;
    bus.CPU_WE   = 1'b0;
    bus.CPU_ADDR = '0;
    bus.CPU_WD   = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
  endtask

  // Predict the response from the cache rules, queue it, then run the request to completion.
  task automatic issue(input bit re, input bit we, input int a, input logic [31:0] d);
    exp_t e;
    int   line;
    int   idx;
    int   tg;
    bit   done;
    line = a / 4;
    idx  = line % 32;
    tg   = line / 32;
    if (we) begin
      e.rd       = '0;
      e.stall    = MEM_LAT;
      e.we       = MEM_LAT;
      ref_mem[a] = d;
    end else begin
      e.rd  = ref_mem[a];
      e.we  = 0;
      e.stall = (ref_valid[idx] && ref_tag[idx] == tg) ? 0 : 4 * MEM_LAT + 1;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.CPU_RE   = re;
    bus.CPU_WE   = we;
    bus.CPU_ADDR = addr_t'(a);
    bus.CPU_WD   = d;
    mon_en       = 1'b1;
    done         = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (bus.STALL === 1'b0) done = 1'b1;
    end
    if (!done) begin
      check("request_timeout", 32'(0), 32'(1));
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  initial begin
    bit found;
    int a;
    int r;
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(255 - i);
    model_reset();

    // Reset with a request pending: all outputs must be held at zero.
    rst          = 1'b1;
    bus.CPU_RE   = 1'b1;
    bus.CPU_WE   = 1'b1;
    bus.CPU_ADDR = 10'h2A5;
    bus.CPU_WD   = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(bus.STALL), 32'(0));
    check("rst_mem_we", 32'(bus.MEM_WE), 32'(0));
    check("rst_mem_a", 32'(bus.MEM_A), 32'(0));
    check("rst_mem_wd", bus.MEM_WD, 32'(0));
    check("rst_cpu_rd", bus.CPU_RD, 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    check("idle_stall", 32'(bus.STALL), 32'(0));

    // Refill, hit, store-hit, store-miss, conflict misses.
    issue(1'b1, 1'b0, 'h000, 'x);
    issue(1'b1, 1'b0, 'h001, 'x);
    issue(1'b0, 1'b1, 'h002, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 'h002, 'x);
    issue(1'b0, 1'b1, 'h100, 32'h12345678);
    issue(1'b1, 1'b0, 'h100, 'x);
    issue(1'b1, 1'b0, 'h000, 'x);
    issue(1'b1, 1'b0, 'h080, 'x);
    issue(1'b1, 1'b0, 'h000, 'x);
    issue(1'b1, 1'b0, 'h003, 'x);

    // Reset in the middle of a refill; the line must come back invalid.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    bus.CPU_RE   = 1'b1;
    bus.CPU_ADDR = 10'h040;
    found        = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (bus.MEM_A === 10'h042) found = 1'b1;
    end
    check("refill_reaches_042", 32'(found), 32'(1));
    rst = 1'b1;
    #1;
    check("abort_stall", 32'(bus.STALL), 32'(0));
    check("abort_mem_we", 32'(bus.MEM_WE), 32'(0));
    @(posedge clk);
    #1;
    check("abort_stall_edge", 32'(bus.STALL), 32'(0));
    rst = 1'b0;
    drive_idle();
    model_reset();
    issue(1'b1, 1'b0, 'h040, 'x);
    issue(1'b1, 1'b0, 'h000, 'x);

    // Simultaneous load and store request behaves as a store.
    issue(1'b1, 1'b1, 'h005, 32'd7);
    issue(1'b1, 1'b0, 'h005, 'x);
    issue(1'b1, 1'b1, 'h005, 32'd9);
    issue(1'b1, 1'b0, 'h005, 'x);

    // Random traffic over a few indices so that hits, conflicts and store hits all occur.
    for (int n = 0; n < 250; n++) begin
      a = ($urandom_range(0, 7) * 128) + ($urandom_range(0, 3) * 4) + $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r < 6)      issue(1'b1, 1'b0, a, 'x);
      else if (r < 9) issue(1'b0, 1'b1, a, $urandom);
      else            issue(1'b1, 1'b1, a, $urandom);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-through, no-write-allocate data cache between the RISC-V core's load/store port and Data_Memory. It serves load hits in zero added cycles and refills a 4-word line on a load miss. Every store is forwarded to memory. STALL freezes the core while the cache or memory is busy. Its memory-side ports connect directly to Data_Memory's A/WD/WE/RD.

Parameters:
ADDR_W, 10, word address width (matches Data_Memory A)
DATA_W, 32, data word width
INDEX_W, 5, line index bits (32 lines)
OFFSET_W, 2, word-in-line bits (4 words/line); tag width = ADDR_W-INDEX_W-OFFSET_W = 3
MEM_LAT, 2, memory cycles per word access (>=1)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  reset, synchronous, active-high
CPU_ADDR  in  ADDR_W  word address of load/store
CPU_WD  in  DATA_W  store data
CPU_RE  in  1  load request
CPU_WE  in  1  store request
CPU_RD  out  DATA_W  load data, valid when CPU_RE=1 and STALL=0
STALL  out  1  core must hold its request and not advance
MEM_A  out  ADDR_W  to Data_Memory A
MEM_WD  out  DATA_W  to Data_Memory WD
MEM_WE  out  1  to Data_Memory WE
MEM_RD  in  DATA_W  from Data_Memory RD

Behaviour:
- Address split: offset=[1:0], index=[6:2], tag=[9:7]. Per line: valid bit, tag, 4 data words.
- States: IDLE, REFILL, WRITE. Counters: word counter (OFFSET_W bits) and latency counter (0..MEM_LAT-1).
- Reset (RST high at an edge): state=IDLE, all valid bits cleared, counters=0. While RST is high: STALL=0, MEM_WE=0, MEM_A=0, MEM_WD=0, CPU_RD=0. Data/tag arrays need no reset.
- IDLE, no request: STALL=0, MEM_WE=0, CPU_RD=0.
- IDLE, load hit (valid and tag match): CPU_RD=selected word combinationally, STALL=0. No state change.
- IDLE, load miss: STALL=1 combinationally. Next state is REFILL with word counter=0 and latency counter=0.
- REFILL:
  - STALL=1, MEM_WE=0, MEM_A={req tag, req index, word counter}.
  - On the edge where latency counter=MEM_LAT-1, capture MEM_RD into that line word and advance the word counter.
  - After word 3 is captured, set valid, write the tag, and go to IDLE.
  - The load then hits in IDLE. Total STALL for a load miss = 4*MEM_LAT+1 cycles; data is returned in the following cycle.
- IDLE, store (CPU_WE=1): STALL=1 and the next state is WRITE. If the access hits, the cached word is updated with CPU_WD on this edge. On a miss, the cache is untouched (no allocate).
- WRITE:
  - MEM_A=CPU_ADDR, MEM_WD=CPU_WD, MEM_WE=1 for MEM_LAT cycles.
  - STALL=1 except in the final WRITE cycle, where STALL=0 so the core retires the store on that edge.
  - Then go to IDLE.
- CPU_RE and CPU_WE both high: treated as a store; CPU_RD=0.
- The core holds CPU_ADDR, CPU_WD, CPU_RE and CPU_WE stable while STALL=1. The controller latches the miss address at REFILL entry so refill is robust anyway.
- RST during REFILL or WRITE: immediate return to IDLE. The partially filled line stays invalid. MEM_WE drops in the reset cycle.
- Word counter wraps 3->0 only on REFILL exit. Latency counter wraps MEM_LAT-1->0 on each word.

Decomposition:
- Shared package dcache_pkg holds:
  - State enum/localparams (IDLE, REFILL, WRITE)
  - Width localparams: tag width, lines = 2**INDEX_W, words per line
  - Address-field slice helpers
- One natural sub-module: dcache_line_store. It holds the valid/tag/data arrays and provides a combinational read port, a synchronous word write, and a synchronous tag/valid set plus clear-all.

Test Plan:
1. Preload mem[i]=255-i, MEM_LAT=2. Reset, then load 0x000 -> STALL high 9 cycles, MEM_A steps 0,1,2,3 (2 cycles each), CPU_RD=255. Next, load 0x001 -> STALL=0 same cycle, CPU_RD=254.
2. After test 1, store 0xDEADBEEF to 0x002 -> MEM_WE=1 for 2 cycles with MEM_A=0x002. STALL is high 2 cycles (IDLE plus first WRITE). A following load of 0x002 hits with STALL=0 and CPU_RD=0xDEADBEEF.
3. Store 0x12345678 to 0x100 (miss) -> memory written, no refill. A subsequent load of 0x100 misses (9-cycle stall) and returns 0x12345678.
4. Load 0x000, then 0x080 (same index 0, tag 1) -> second access misses and refills. Load 0x000 again -> misses again, CPU_RD=255.
5. Start a load miss on 0x040 and assert RST while MEM_A=0x042 -> STALL=0 and MEM_WE=0 during reset. Reload 0x040 -> full 9-cycle miss.
6. CPU_RE=CPU_WE=1 at 0x005 with data 7 -> store path (MEM_WE pulses, no refill, CPU_RD=0). A later load of 0x005 returns 7.
